// File: rtl/tft_window_gate.sv
// tft_window_gate
// Gates a parallel RGB TFT pixel stream so that only pixels inside one of
// NWIN movable rectangular windows pass; everything else is driven black.
// Window origins are nudged by MOVE pulses. The pulses accumulate as pending
// offsets and are applied only at the frame boundary, so a frame is never
// torn.
//
// Ports
//   CLK, nRESET                  clock, synchronous active-low reset
//   PIX_EN                       pixel strobe; pixel-path inputs are sampled only when high
//   HSYNC_IN, VSYNC_IN, DE_IN    active-low syncs and data enable of the source
//   R_IN, G_IN, B_IN             source pixel
//   MOVE                         {up, down, left, right} single-cycle pulses
//   SEL, STEP_SEL                target window index, step select (0 small, 1 large)
//   R, G, B                      gated pixel
//   HSYNC_OUT, VSYNC_OUT, DE_OUT syncs and data enable, aligned with R, G and B
//   IN_WIN                       per-window hit flags of the output pixel
//
// Build option
//   TFT_WIN_BORDER_EN            when defined, draws each window's outermost
//                                rows and columns as all-ones
module tft_window_gate #(
    parameter int unsigned CW       = 8,
    parameter int unsigned H_ACTIVE = 480,
    parameter int unsigned V_ACTIVE = 272,
    parameter int unsigned NWIN     = 2,
    parameter int unsigned WIN_W    = 64,
    parameter int unsigned WIN_H    = 48,
    parameter int unsigned STEP_S   = 5,
    parameter int unsigned STEP_L   = 10
) (
    input  logic            CLK,
    input  logic            nRESET,
    input  logic            PIX_EN,
    input  logic            HSYNC_IN,
    input  logic            VSYNC_IN,
    input  logic            DE_IN,
    input  logic [CW-1:0]   R_IN,
    input  logic [CW-1:0]   G_IN,
    input  logic [CW-1:0]   B_IN,
    input  logic [3:0]      MOVE,
    input  logic [1:0]      SEL,
    input  logic            STEP_SEL,
    output logic [CW-1:0]   R,
    output logic [CW-1:0]   G,
    output logic [CW-1:0]   B,
    output logic            HSYNC_OUT,
    output logic            VSYNC_OUT,
    output logic            DE_OUT,
    output logic [NWIN-1:0] IN_WIN
);
    localparam int unsigned CNT_W = 10;
    localparam int unsigned AW    = 12;
    localparam logic [AW-1:0] X_MAX = AW'(H_ACTIVE - WIN_W);
    localparam logic [AW-1:0] Y_MAX = AW'(V_ACTIVE - WIN_H);

    logic [CNT_W-1:0]     hcnt, vcnt;
    logic                 hs_q, vs_q, de_q;
    logic [AW-1:0]        x0 [NWIN];
    logic [AW-1:0]        y0 [NWIN];
    logic signed [AW-1:0] dx [NWIN];
    logic signed [AW-1:0] dy [NWIN];

    logic                 hs_fall, vs_fall, de_fall;
    logic signed [AW-1:0] step, mv_dx, mv_dy;
    logic signed [AW-1:0] dx_nxt [NWIN];
    logic signed [AW-1:0] dy_nxt [NWIN];
    logic [AW-1:0]        x0_nxt [NWIN];
    logic [AW-1:0]        y0_nxt [NWIN];
    logic [AW-1:0]        hpos, vpos;
    logic [NWIN-1:0]      hit;
    logic [CW-1:0]        r_nxt, g_nxt, b_nxt;
`ifdef TFT_WIN_BORDER_EN
    logic [NWIN-1:0]      edge_px;
`endif

    // Saturate a signed candidate origin into [0, hi].
    function automatic logic [AW-1:0] clamp(input logic signed [AW-1:0] v,
                                            input logic [AW-1:0] hi);
        if (v[AW-1]) return '0;
        if ($unsigned(v) > hi) return hi;
        return $unsigned(v);
    endfunction

    // Reset origin: windows tiled left to right, last ones pushed to the edge.
    function automatic logic [AW-1:0] x_default(input int unsigned k);
        return (k * WIN_W > H_ACTIVE - WIN_W) ? X_MAX : AW'(k * WIN_W);
    endfunction

    // Edge detects, move decoding, window hit and next-pixel data.
    always_comb begin
        hs_fall = PIX_EN & hs_q & ~HSYNC_IN;
        vs_fall = PIX_EN & vs_q & ~VSYNC_IN;
        de_fall = PIX_EN & de_q & ~DE_IN;

        step  = STEP_SEL ? AW'(STEP_L) : AW'(STEP_S);
        mv_dx = '0;
        mv_dy = '0;
        if (MOVE[0] && !MOVE[1]) mv_dx = step;
        else if (MOVE[1] && !MOVE[0]) mv_dx = -step;
        if (MOVE[2] && !MOVE[3]) mv_dy = step;
        else if (MOVE[3] && !MOVE[2]) mv_dy = -step;

        hpos = AW'(hcnt);
        vpos = AW'(vcnt);
        hit  = '0;
`ifdef TFT_WIN_BORDER_EN
        edge_px = '0;
`endif
        for (int unsigned k = 0; k < NWIN; k++) begin
            x0_nxt[k] = clamp($signed(x0[k]) + dx[k], X_MAX);
            y0_nxt[k] = clamp($signed(y0[k]) + dy[k], Y_MAX);
            // A pulse in the boundary cycle survives into the fresh accumulator.
            dx_nxt[k] = vs_fall ? '0 : dx[k];
            dy_nxt[k] = vs_fall ? '0 : dy[k];
            if (SEL == 2'(k)) begin
                dx_nxt[k] = dx_nxt[k] + mv_dx;
                dy_nxt[k] = dy_nxt[k] + mv_dy;
            end
            hit[k] = (hpos >= x0[k]) && (hpos < x0[k] + AW'(WIN_W)) &&
                     (vpos >= y0[k]) && (vpos < y0[k] + AW'(WIN_H));
`ifdef TFT_WIN_BORDER_EN
            edge_px[k] = hit[k] &&
                         ((hpos == x0[k]) || (hpos == x0[k] + AW'(WIN_W - 1)) ||
                          (vpos == y0[k]) || (vpos == y0[k] + AW'(WIN_H - 1)));
`endif
        end

        r_nxt = '0;
        g_nxt = '0;
        b_nxt = '0;
        if (DE_IN && (|hit)) begin
            r_nxt = R_IN;
            g_nxt = G_IN;
            b_nxt = B_IN;
`ifdef TFT_WIN_BORDER_EN
            if (|edge_px) begin
                r_nxt = '1;
                g_nxt = '1;
                b_nxt = '1;
            end
`endif
        end
    end

    // Counters, origins, pending offsets and registered outputs.
    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            hcnt      <= '0;
            vcnt      <= '0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            de_q      <= 1'b0;
            R         <= '0;
            G         <= '0;
            B         <= '0;
            HSYNC_OUT <= 1'b1;
            VSYNC_OUT <= 1'b1;
            DE_OUT    <= 1'b0;
            IN_WIN    <= '0;
            for (int unsigned k = 0; k < NWIN; k++) begin
                x0[k] <= x_default(k);
                y0[k] <= '0;
                dx[k] <= '0;
                dy[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < NWIN; k++) begin
                dx[k] <= dx_nxt[k];
                dy[k] <= dy_nxt[k];
                if (vs_fall) begin
                    x0[k] <= x0_nxt[k];
                    y0[k] <= y0_nxt[k];
                end
            end
            if (PIX_EN) begin
                hs_q <= HSYNC_IN;
                vs_q <= VSYNC_IN;
                de_q <= DE_IN;
                if (hs_fall) hcnt <= '0;
                else if (DE_IN) hcnt <= hcnt + CNT_W'(1);
                if (vs_fall) vcnt <= '0;
                else if (de_fall) vcnt <= vcnt + CNT_W'(1);
                R         <= r_nxt;
                G         <= g_nxt;
                B         <= b_nxt;
                HSYNC_OUT <= HSYNC_IN;
                VSYNC_OUT <= VSYNC_IN;
                DE_OUT    <= DE_IN;
                IN_WIN    <= DE_IN ? hit : '0;
            end
        end
    end
endmodule
